// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single DataMemo port between the CPU load/store
// unit (port 0) and the DMA/debug loader (port 1). Each access is a
// req/ack transaction: IDLE -> ACCESS -> RESP -> IDLE. A tie between the
// two ports goes round-robin or to port 0, depending on RR_EN. Addresses are
// byte addresses; bit 0 here is the spec's bit 1.
module dm_arbiter #(
  parameter logic RR_EN = 1'b1  // 1: round-robin on ties, 0: port 0 always wins
) (
  input  logic        clk,
  input  logic        RST,       // asynchronous, active low
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic [1:0]  mem_mode,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_reg;
  logic        last_grant_reg;   // port granted most recently
  logic        gnt_reg;          // port owning the current transaction
  logic        req_we_reg;
  logic [11:0] req_addr_reg;
  logic [31:0] req_din_reg;
  logic [1:0]  req_mode_reg;
  logic        req_err_reg;
  logic        mem_we_reg;
  logic        busy_reg;
  logic        ack0_reg;
  logic        ack1_reg;
  logic        err0_reg;
  logic        err1_reg;
  logic [31:0] rdata0_reg;
  logic [31:0] rdata1_reg;

  logic        sel_next;
  logic        sel_we_next;
  logic [11:0] sel_addr_next;
  logic [31:0] sel_din_next;
  logic [1:0]  sel_mode_next;
  logic        sel_err_next;

  // Access is rejected when the address does not match the width, or the
  // width encoding is the reserved one.
  function automatic logic bad_access(input logic [1:0] mode, input logic [11:0] addr);
    logic bad;
    case (mode)
      2'b00:   bad = (addr[1:0] != 2'b00);
      2'b01:   bad = addr[0];
      2'b10:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the winning port and mux its request fields.
  always_comb begin
    sel_next = 1'b0;
    if (req0 && req1) begin
      sel_next = RR_EN ? ~last_grant_reg : 1'b0;
    end else if (req1) begin
      sel_next = 1'b1;
    end
    sel_we_next   = sel_next ? we1   : we0;
    sel_addr_next = sel_next ? addr1 : addr0;
    sel_din_next  = sel_next ? din1  : din0;
    sel_mode_next = sel_next ? mode1 : mode0;
    sel_err_next  = bad_access(sel_mode_next, sel_addr_next);
  end

  // Sequencer FSM with registered outputs; ack/err pulse only while in RESP.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      gnt_reg        <= 1'b0;
      req_we_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_din_reg    <= '0;
      req_mode_reg   <= '0;
      req_err_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      err0_reg       <= 1'b0;
      err1_reg       <= 1'b0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      err0_reg <= 1'b0;
      err1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            gnt_reg        <= sel_next;
            last_grant_reg <= sel_next;
            req_we_reg     <= sel_we_next;
            req_addr_reg   <= sel_addr_next;
            req_din_reg    <= sel_din_next;
            req_mode_reg   <= sel_mode_next;
            req_err_reg    <= sel_err_next;
            // write strobe is suppressed for rejected stores
            mem_we_reg     <= sel_we_next & ~sel_err_next;
            busy_reg       <= 1'b1;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_reg <= 1'b0;
          if (!req_we_reg && !req_err_reg) begin
            if (gnt_reg) rdata1_reg <= mem_dout;
            else         rdata0_reg <= mem_dout;
          end
          if (gnt_reg) begin
            ack1_reg <= 1'b1;
            err1_reg <= req_err_reg;
          end else begin
            ack0_reg <= 1'b1;
            err0_reg <= req_err_reg;
          end
          state_reg <= RESP;
        end
        RESP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          mem_we_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign ack0     = ack0_reg;
  assign ack1     = ack1_reg;
  assign err0     = err0_reg;
  assign err1     = err1_reg;
  assign rdata0   = rdata0_reg;
  assign rdata1   = rdata1_reg;
  assign busy     = busy_reg;
  assign mem_addr = req_addr_reg;
  assign mem_din  = req_din_reg;
  assign mem_mode = req_mode_reg;
  assign mem_we   = mem_we_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: one round-robin instance and one fixed-priority
// instance, each with a byte-addressed little-endian memory model.
module tb_dm_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mem_init;

  // index i = 2*dut + port; dut 0 = round-robin, dut 1 = fixed priority
  logic        req_s  [4];
  logic        we_s   [4];
  logic [11:0] addr_s [4];
  logic [31:0] din_s  [4];
  logic [1:0]  mode_s [4];
  logic        ack_s  [4];
  logic        err_s  [4];
  logic [31:0] rd_s   [4];

  logic        busy_s  [2];
  logic        mwe_s   [2];
  logic [11:0] maddr_s [2];
  logic [31:0] mdin_s  [2];
  logic [31:0] mdout_s [2];
  logic [1:0]  mmode_s [2];

  dm_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .RST(rst_n),
    .req0(req_s[0]), .req1(req_s[1]), .we0(we_s[0]), .we1(we_s[1]),
    .addr0(addr_s[0]), .addr1(addr_s[1]), .din0(din_s[0]), .din1(din_s[1]),
    .mode0(mode_s[0]), .mode1(mode_s[1]),
    .ack0(ack_s[0]), .ack1(ack_s[1]), .err0(err_s[0]), .err1(err_s[1]),
    .rdata0(rd_s[0]), .rdata1(rd_s[1]), .busy(busy_s[0]),
    .mem_addr(maddr_s[0]), .mem_din(mdin_s[0]), .mem_we(mwe_s[0]),
    .mem_mode(mmode_s[0]), .mem_dout(mdout_s[0])
  );

  dm_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .RST(rst_n),
    .req0(req_s[2]), .req1(req_s[3]), .we0(we_s[2]), .we1(we_s[3]),
    .addr0(addr_s[2]), .addr1(addr_s[3]), .din0(din_s[2]), .din1(din_s[3]),
    .mode0(mode_s[2]), .mode1(mode_s[3]),
    .ack0(ack_s[2]), .ack1(ack_s[3]), .err0(err_s[2]), .err1(err_s[3]),
    .rdata0(rd_s[2]), .rdata1(rd_s[3]), .busy(busy_s[1]),
    .mem_addr(maddr_s[1]), .mem_din(mdin_s[1]), .mem_we(mwe_s[1]),
    .mem_mode(mmode_s[1]), .mem_dout(mdout_s[1])
  );

  // ---------------- memory models ----------------
  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];

  function automatic logic [31:0] rmask(input logic [1:0] mode, input logic [31:0] w);
    case (mode)
      2'b00:   return w;
      2'b01:   return {16'h0000, w[15:0]};
      2'b10:   return {24'h000000, w[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  assign mdout_s[0] = rmask(mmode_s[0], {mem0[maddr_s[0] + 12'd3], mem0[maddr_s[0] + 12'd2],
                                         mem0[maddr_s[0] + 12'd1], mem0[maddr_s[0]]});
  assign mdout_s[1] = rmask(mmode_s[1], {mem1[maddr_s[1] + 12'd3], mem1[maddr_s[1] + 12'd2],
                                         mem1[maddr_s[1] + 12'd1], mem1[maddr_s[1]]});

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 4096; k++) mem0[k] <= 8'h00;
    end else if (mwe_s[0] === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (b < nbytes(mmode_s[0])) mem0[maddr_s[0] + 12'(b)] <= mdin_s[0][8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 4096; k++) mem1[k] <= 8'h00;
    end else if (mwe_s[1] === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (b < nbytes(mmode_s[1])) mem1[maddr_s[1] + 12'(b)] <= mdin_s[1][8*b +: 8];
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq [4][$];
  int          goq [2][$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          we_cnt   [2];
  logic [11:0] acc_addr [2];
  logic [1:0]  acc_mode [2];
  int          last_ack_cyc [4];
  bit          gap_en   [2];
  int          gap_prev [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops the expectation for that port and the grant order
  initial begin
    for (int d = 0; d < 2; d++) begin
      we_cnt[d] = 0; gap_en[d] = 1'b0; gap_prev[d] = -1;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mwe_s[d] === 1'b1) we_cnt[d]++;
        if (busy_s[d] === 1'b1 && ack_s[2*d] !== 1'b1 && ack_s[2*d+1] !== 1'b1) begin
          acc_addr[d] = maddr_s[d];
          acc_mode[d] = mmode_s[d];
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (ack_s[i] === 1'b1) begin
          exp_t e;
          int   d;
          d = i / 2;
          $display("TXN dut=%0d port=%0d err=%0b rdata=0x%08h cyc=%0d", d, i % 2, err_s[i], rd_s[i], cyc);
          if (sbq[i].size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ack: got ack on dut %0d port %0d, required none", d, i % 2);
          end else begin
            e = sbq[i].pop_front();
            chk("err", 32'(err_s[i]), 32'(e.err));
            chk("rdata", rd_s[i], e.rd);
          end
          if (goq[d].size() == 0) begin
            checks++; failures++;
            $display("FAIL grant_order: got port %0d, required no grant", i % 2);
          end else begin
            chk("grant_order", 32'(i % 2), 32'(goq[d].pop_front()));
          end
          if (gap_en[d]) begin
            if (gap_prev[d] >= 0) chk("ack_gap", 32'(cyc - gap_prev[d]), 32'd3);
            gap_prev[d] = cyc;
          end
          last_ack_cyc[i] = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int d, input int p, input logic we, input logic [11:0] a,
                       input logic [31:0] din, input logic [1:0] mode,
                       input logic xerr, input logic [31:0] xrd);
    int   i;
    exp_t e;
    bit   got;
    i = d * 2 + p;
    got = 1'b0;
    @(posedge clk); #1;
    e.err = xerr;
    e.rd  = xrd;
    sbq[i].push_back(e);
    req_s[i] = 1'b1; we_s[i] = we; addr_s[i] = a; din_s[i] = din; mode_s[i] = mode;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (ack_s[i] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout: dut %0d port %0d got no ack, required one within 40 cycles", d, p);
    end
    req_s[i] = 1'b0;
  endtask

  task automatic one(input int d, input int p, input logic we, input logic [11:0] a,
                     input logic [31:0] din, input logic [1:0] mode,
                     input logic xerr, input logic [31:0] xrd);
    goq[d].push_back(p);
    issue(d, p, we, a, din, mode, xerr, xrd);
  endtask

  initial begin
    int base;
    bit hit;
    rst_n = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; din_s[i] = '0; mode_s[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    // reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy_s[d]), 32'd0);
      chk("rst_mem_we", 32'(mwe_s[d]), 32'd0);
      chk("rst_mem_addr", 32'(maddr_s[d]), 32'd0);
      chk("rst_mem_din", mdin_s[d], 32'd0);
      chk("rst_mem_mode", 32'(mmode_s[d]), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("rst_ack", 32'(ack_s[i]), 32'd0);
      chk("rst_err", 32'(err_s[i]), 32'd0);
      chk("rst_rdata", rd_s[i], 32'd0);
    end
    @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;

    // word store then load on port 0
    base = we_cnt[0];
    one(0, 0, 1'b1, 12'h004, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
    chk("store_we_cycles", 32'(we_cnt[0] - base), 32'd1);
    one(0, 0, 1'b0, 12'h004, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF);
    one(0, 0, 1'b1, 12'h020, 32'h33334444, 2'b00, 1'b0, 32'hDEADBEEF);
    one(0, 1, 1'b1, 12'h010, 32'h11112222, 2'b00, 1'b0, 32'h0);

    // simultaneous requests, round-robin: 0,1,0,1 three cycles apart
    goq[0].push_back(0); goq[0].push_back(1); goq[0].push_back(0); goq[0].push_back(1);
    gap_en[0] = 1'b1; gap_prev[0] = -1;
    fork
      begin
        issue(0, 0, 1'b0, 12'h020, 32'h0, 2'b00, 1'b0, 32'h33334444);
        issue(0, 0, 1'b0, 12'h020, 32'h0, 2'b00, 1'b0, 32'h33334444);
      end
      begin
        issue(0, 1, 1'b0, 12'h010, 32'h0, 2'b00, 1'b0, 32'h11112222);
        issue(0, 1, 1'b0, 12'h010, 32'h0, 2'b00, 1'b0, 32'h11112222);
      end
    join
    gap_en[0] = 1'b0;

    // misaligned / reserved accesses: err with ack, no write, rdata held
    base = we_cnt[0];
    one(0, 0, 1'b1, 12'h006, 32'h12345678, 2'b00, 1'b1, 32'h33334444);
    one(0, 0, 1'b1, 12'h003, 32'h12345678, 2'b01, 1'b1, 32'h33334444);
    one(0, 0, 1'b1, 12'h004, 32'h12345678, 2'b11, 1'b1, 32'h33334444);
    one(0, 0, 1'b0, 12'h004, 32'h0,        2'b11, 1'b1, 32'h33334444);
    chk("err_no_we", 32'(we_cnt[0] - base), 32'd0);
    one(0, 0, 1'b0, 12'h004, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF);
    one(0, 0, 1'b0, 12'h004, 32'h0, 2'b01, 1'b0, 32'h0000BEEF);

    // byte pass-through on port 1
    one(0, 1, 1'b1, 12'h009, 32'h000000A5, 2'b10, 1'b0, 32'h11112222);
    chk("byte_acc_addr", 32'(acc_addr[0]), 32'h009);
    chk("byte_acc_mode", 32'(acc_mode[0]), 32'h2);
    one(0, 1, 1'b0, 12'h009, 32'h0, 2'b10, 1'b0, 32'h000000A5);

    // fixed priority: port 1 waits while port 0 keeps re-requesting
    goq[1].push_back(0); goq[1].push_back(0); goq[1].push_back(0); goq[1].push_back(1);
    fork
      begin
        issue(1, 0, 1'b1, 12'h000, 32'hCAFEF00D, 2'b00, 1'b0, 32'h0);
        issue(1, 0, 1'b0, 12'h000, 32'h0, 2'b00, 1'b0, 32'hCAFEF00D);
        issue(1, 0, 1'b0, 12'h000, 32'h0, 2'b00, 1'b0, 32'hCAFEF00D);
      end
      begin
        issue(1, 1, 1'b0, 12'h000, 32'h0, 2'b00, 1'b0, 32'hCAFEF00D);
      end
    join
    chk("fp_port1_latency", 32'(last_ack_cyc[3] - last_ack_cyc[2]), 32'd3);

    // reset during ACCESS of a store on the round-robin instance
    @(posedge clk); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 12'h030; din_s[0] = 32'h55AA55AA; mode_s[0] = 2'b00;
    hit = 1'b0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(negedge clk);
      if (busy_s[0] === 1'b1 && ack_s[0] !== 1'b1) hit = 1'b1;
    end
    chk("pre_rst_access_seen", 32'(hit), 32'd1);
    chk("pre_rst_mem_we", 32'(mwe_s[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_we", 32'(mwe_s[0]), 32'd0);
    chk("rst_mid_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_mid_rdata0", rd_s[0], 32'd0);
    req_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goq[0].push_back(0); goq[0].push_back(1);
    fork
      issue(0, 0, 1'b0, 12'h004, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF);
      issue(0, 1, 1'b0, 12'h030, 32'h0, 2'b00, 1'b0, 32'h0);
    join

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);
    chk("order_drained", 32'(goq[0].size() + goq[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
